// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and instruction record for the ALU op sequencer
package alu_seq_pkg;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_RESET = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b1001;

    // Default field widths of an instruction record
    localparam int SEQ_W     = 2;
    localparam int SEQ_RPT_W = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [3:0]           opcode;
        logic [SEQ_W-1:0]     operand;
        logic [SEQ_RPT_W-1:0] rpt;
    } instr_t;

    // True for the four opcodes the ALU actually implements
    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_NOOP) || (op == OP_RESET) || (op == OP_ADD) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// rtl/seq_fifo.sv - synchronous instruction FIFO with full/empty/occupancy
module seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = $bits(instr_t)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid,
    input  logic [DW-1:0]          s_tdata,
    input  logic                   m_tready,
    output logic [DW-1:0]          m_tdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push;
    logic          pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign push    = s_tvalid & ~full;
    assign pop     = m_tready & ~empty;
    assign m_tdata = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push while full is dropped even if a pop happens too
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues queued instructions to the accumulator ALU; ALU_SEQ_STATS_EN adds stat_issued
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = SEQ_W,
    parameter int RPT_W = SEQ_RPT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_opcode,
    input  logic [W-1:0]           in_operand,
    input  logic [RPT_W-1:0]       in_repeat,
    input  logic                   start,
    input  logic                   halt,
    output logic [3:0]             alu_opcode,
    output logic [W-1:0]           alu_operand,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_illegal
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]            stat_issued
`endif
);

    typedef struct packed {
        logic [3:0]       opcode;
        logic [W-1:0]     operand;
        logic [RPT_W-1:0] rpt;
    } entry_t;

    seq_state_t       state;
    entry_t           push_d;
    entry_t           head;
    logic             full;
    logic             empty;
    logic             pop;
    logic             run_go;
    logic [3:0]       head_issue;
    logic [3:0]       cur_opcode;
    logic [W-1:0]     cur_operand;
    logic [RPT_W-1:0] rem;

    assign push_d   = '{opcode: in_opcode, operand: in_operand, rpt: in_repeat};
    assign in_ready = ~full;
    assign busy     = (state == ST_RUN) || (state == ST_HALTED);

    // Issue step happens in RUN without halt, or on the edge that resumes from HALTED
    assign run_go     = ~halt && ((state == ST_RUN) || ((state == ST_HALTED) && start));
    assign pop        = run_go && (rem == '0) && ~empty;
    assign head_issue = is_legal(head.opcode) ? head.opcode : OP_NOOP;

    seq_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (in_valid),
        .s_tdata  (push_d),
        .m_tready (pop),
        .m_tdata  (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Sequencer FSM and registered ALU drive
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_INIT;
            alu_opcode  <= OP_NOOP;
            alu_operand <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            rem         <= '0;
            cur_opcode  <= OP_NOOP;
            cur_operand <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_INIT: begin
                    alu_opcode  <= OP_RESET;
                    alu_operand <= '0;
                    state       <= ST_IDLE;
                end
                ST_IDLE: begin
                    alu_opcode  <= OP_NOOP;
                    alu_operand <= '0;
                    if (start) state <= ST_RUN;
                end
                default: begin
                    if (!run_go) begin
                        alu_opcode  <= OP_NOOP;
                        alu_operand <= '0;
                        state       <= ST_HALTED;
                    end else if (rem != '0) begin
                        alu_opcode  <= cur_opcode;
                        alu_operand <= cur_operand;
                        rem         <= rem - RPT_W'(1);
                        state       <= ST_RUN;
                    end else if (!empty) begin
                        alu_opcode  <= head_issue;
                        alu_operand <= head.operand;
                        cur_opcode  <= head_issue;
                        cur_operand <= head.operand;
                        rem         <= head.rpt;
                        state       <= ST_RUN;
                        if (!is_legal(head.opcode)) err_illegal <= 1'b1;
                    end else begin
                        alu_opcode  <= OP_NOOP;
                        alu_operand <= '0;
                        done        <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic issue_live;

    // Edges that will register a non-NOOP opcode onto alu_opcode
    assign issue_live = (state == ST_INIT) ||
                        (run_go && (rem != '0) && (cur_opcode != OP_NOOP)) ||
                        (pop && (head_issue != OP_NOOP));

    // Saturating count of non-NOOP issue cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_issued <= '0;
        end else if (issue_live && (stat_issued != 16'hFFFF)) begin
            stat_issued <= stat_issued + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with an accumulator ALU model
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_opcode = 4'd0;
    logic [1:0] in_operand = 2'd0;
    logic [1:0] in_repeat = 2'd0;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       in_ready;
    logic [3:0] alu_opcode;
    logic [1:0] alu_operand;
    logic       busy;
    logic       done;
    logic [2:0] count;
    logic       err_illegal;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_issued;
`endif

    alu_op_sequencer #(.DEPTH(4), .W(2), .RPT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_operand  (in_operand),
        .in_repeat   (in_repeat),
        .start       (start),
        .halt        (halt),
        .alu_opcode  (alu_opcode),
        .alu_operand (alu_operand),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .err_illegal (err_illegal)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_issued (stat_issued)
`endif
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];
    bit         mon_en = 1'b0;
    bit         busy_seen = 1'b0;
    logic [1:0] acc = 2'b11;

    typedef struct {
        logic [3:0] op;
        logic [1:0] opd;
        logic [1:0] rpt;
        bit         exp_ready;
        int         exp_count;
    } vec_t;
    vec_t tbl[5];

    // Accumulator ALU the sequencer drives
    always @(posedge clk) begin
        case (alu_opcode)
            4'b0001: acc <= 2'b00;
            4'b0101: acc <= acc + alu_operand;
            4'b1001: acc <= acc & alu_operand;
            default: acc <= acc;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] tb_issue(input logic [3:0] op);
        return (op == 4'd0 || op == 4'd1 || op == 4'd5 || op == 4'd9) ? op : 4'd0;
    endfunction

    // Scoreboard: every busy cycle after the start-edge NOOP must match the next expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy && busy_seen) begin
                if (exp_q.size() == 0) begin
                    check("issue_extra", alu_opcode, 4'hF);
                end else begin
                    check("issue_seq", alu_opcode, exp_q.pop_front());
                end
            end
            busy_seen = busy;
        end else begin
            busy_seen = 1'b0;
        end
    end

    // Called at a negedge; returns at the next negedge with in_valid low
    task automatic push_instr(input logic [3:0] op, input logic [1:0] opd, input logic [1:0] rpt,
                              input bit exp_accept, input bit add_exp);
        in_opcode  = op;
        in_operand = opd;
        in_repeat  = rpt;
        in_valid   = 1'b1;
        check("in_ready", in_ready, exp_accept);
        if (exp_accept && add_exp) begin
            for (int k = 0; k <= int'(rpt); k++) exp_q.push_back(tb_issue(op));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        check({name, "_done"}, got, 1);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("init_reset_op", alu_opcode, 4'b0001);
        @(negedge clk);
        check("init_then_noop", alu_opcode, 4'b0000);
        mon_en = 1'b1;
    endtask

    initial begin
        tbl[0] = '{op: 4'b0101, opd: 2'b01, rpt: 2'd0, exp_ready: 1'b1, exp_count: 1};
        tbl[1] = '{op: 4'b0101, opd: 2'b10, rpt: 2'd0, exp_ready: 1'b1, exp_count: 2};
        tbl[2] = '{op: 4'b1001, opd: 2'b10, rpt: 2'd0, exp_ready: 1'b1, exp_count: 3};
        tbl[3] = '{op: 4'b0101, opd: 2'b11, rpt: 2'd0, exp_ready: 1'b1, exp_count: 4};
        tbl[4] = '{op: 4'b0101, opd: 2'b01, rpt: 2'd0, exp_ready: 1'b0, exp_count: 4};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_opcode", alu_opcode, 4'b0000);
        check("rst_operand", alu_operand, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_err", err_illegal, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        check("release_reset_op", alu_opcode, 4'b0001);
        @(negedge clk);
        check("release_noop", alu_opcode, 4'b0000);
        check("release_busy", busy, 0);
        check("release_err", err_illegal, 0);
        mon_en = 1'b1;

        // Basic three-instruction run
        push_instr(4'b0101, 2'b01, 2'd0, 1'b1, 1'b1);
        push_instr(4'b0000, 2'b00, 2'd0, 1'b1, 1'b1);
        push_instr(4'b0101, 2'b01, 2'd0, 1'b1, 1'b1);
        check("s2_count", count, 3);
        pulse_start();
        check("s2_busy", busy, 1);
        wait_done("s2");
        check("s2_acc", acc, 2'b10);
`ifdef ALU_SEQ_STATS_EN
        check("s2_stat_issued", stat_issued, 16'd3);
`endif

        // Repeat with halt/resume, from a freshly reset accumulator
        do_reset();
        check("s3_acc_zero", acc, 2'b00);
        push_instr(4'b0101, 2'b11, 2'd3, 1'b1, 1'b0);
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0101);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("s3_halted_busy", busy, 1);
        halt = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("s3");
        check("s3_acc", acc, 2'b00);

        // Fill to DEPTH, refuse the fifth, then pop+push in RUN
        for (int i = 0; i < 5; i++) begin
            push_instr(tbl[i].op, tbl[i].opd, tbl[i].rpt, tbl[i].exp_ready, 1'b1);
            check("fill_count", count, tbl[i].exp_count);
        end
        pulse_start();
        check("s4_count_start", count, 4);
        @(negedge clk);
        check("s4_count_pop", count, 3);
        push_instr(4'b0101, 2'b01, 2'd0, 1'b1, 1'b1);
        check("s4_count_pushpop", count, 3);
        wait_done("s4");
        check("s4_acc", acc, 2'b10);
        check("s4_err_clear", err_illegal, 0);

        // Illegal opcode issues as NOOP and sets a sticky flag
        push_instr(4'b0111, 2'b10, 2'd1, 1'b1, 1'b1);
        push_instr(4'b0101, 2'b01, 2'd0, 1'b1, 1'b1);
        pulse_start();
        wait_done("s5");
        check("s5_err", err_illegal, 1);
        check("s5_acc", acc, 2'b11);

        // Reset in the middle of a run
        mon_en = 1'b0;
        push_instr(4'b0101, 2'b01, 2'd3, 1'b1, 1'b0);
        push_instr(4'b0101, 2'b01, 2'd0, 1'b1, 1'b0);
        push_instr(4'b0101, 2'b01, 2'd0, 1'b1, 1'b0);
        pulse_start();
        @(negedge clk);
        check("s6_count_mid", count, 2);
        check("s6_issuing", alu_opcode, 4'b0101);
        rst = 1'b0;
        #1;
        check("s6_rst_count", count, 0);
        check("s6_rst_opcode", alu_opcode, 4'b0000);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_err", err_illegal, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s6_reinit_op", alu_opcode, 4'b0001);
`ifdef ALU_SEQ_STATS_EN
        check("s6_stat_after_rst", stat_issued, 16'd1);
`endif
        begin
            int n_add = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (alu_opcode == 4'b0101) n_add++;
            end
            check("s6_no_add", n_add, 0);
            check("s6_count_final", count, 0);
            check("s6_busy_final", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
